cache_fill_controller: RTL
==========================

# cache_fill_controller

- Sequences cache block refills from the shared multi-cycle main memory.
- Arbitrates between I-cache and D-cache misses and issues the eight word reads of a 16-byte block.
- Steers returning words into the granted cache's data array and writes the tag alongside the last word.
- Sits between the two caches' miss logic and the cache interface: it drives the interface's fsm_busy, write_data_array and write_tag_array inputs and owns the memory read address during a fill.

## Interface
- WORDS_PER_BLOCK, 8, 16-bit words per cache block; must be a power of two.
- ADDR_W, 16, address width.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- I_miss  in  1  I-cache miss pending.
- I_miss_addr  in  ADDR_W  address that missed in the I-cache (PC).
- D_miss  in  1  D-cache miss pending.
- D_miss_addr  in  ADDR_W  address that missed in the D-cache.
- memory_data_valid  in  1  memory is returning one read word this cycle.
- fsm_busy  out  1  a fill is in progress.
- grant_I  out  1  the current fill targets the I-cache.
- grant_D  out  1  the current fill targets the D-cache.
- mem_en  out  1  issue a read request to memory this cycle.
- memory_address  out  ADDR_W  word address of the issued read.
- write_data_array  out  1  write the returning word into the granted cache's data array.
- write_tag_array  out  1  write the tag and set the valid bit of the granted cache line.
- fill_word  out  3  word offset within the block for the current data-array write.

## Operation
- States:
  - IDLE: no fill in progress.
  - FILL: read requests and returning words are being handled.
- IDLE transitions:
  - If I_miss or D_miss is high: latch base = miss_addr with bits [3:0] cleared, set the grant, clear issue_cnt and recv_cnt, then go to FILL.
- Arbitration when I_miss and D_miss are both high in the same cycle:
  - Round-robin on a last_grant flop. Grant the side that was not granted last; then update last_grant.
  - After reset, last_grant = I, so D wins the first tie.
  - A single pending miss is always granted, whatever last_grant holds.
- FILL, issue side:
  - mem_en = 1 while issue_cnt < 8.
  - memory_address = {base[15:4], issue_cnt[2:0], 1'b0}.
  - issue_cnt increments on every cycle mem_en is high; it is 4 bits wide and saturates at 8.
- FILL, receive side:
  - Each cycle memory_data_valid is high: write_data_array = 1, fill_word = recv_cnt[2:0], then recv_cnt increments.
- Fill completion:
  - When memory_data_valid is high and recv_cnt == 7: write_data_array = 1 and write_tag_array = 1 in the same cycle.
  - Next state is IDLE.
- The granted miss deasserting mid-fill is ignored; the block always completes.
- A miss from the other cache arriving mid-fill waits. It is arbitrated in IDLE only.
- memory_data_valid is ignored in IDLE, so no output responds to it there.
- Outputs are Moore except write_data_array, write_tag_array and fill_word, which are qualified combinationally by memory_data_valid.
  - fsm_busy = (state == FILL).
  - grant_I / grant_D are registered and held high for the whole fill.

## Timing
- Reset values: state = IDLE, last_grant = I, both counters 0. Every output is 0: fsm_busy, grant_I, grant_D, mem_en, write_data_array, write_tag_array, memory_address = 16'h0000, fill_word = 0.
- Miss seen high in cycle 0 (IDLE) → FILL in cycle 1. Requests issue in cycles 1–8.
- With the 4-cycle memory, words return in cycles 5–12. The tag is written in cycle 12 and fsm_busy falls in cycle 13.
- The tag write takes effect at the cycle-12 edge, so the cache's miss is low by cycle 13. IDLE therefore does not restart a fill for the same block.
- Correct behaviour does not depend on memory latency. A gap-free fill takes 8 + latency cycles plus 1 cycle of entry.
- rst asserted mid-fill: the block is back in IDLE next cycle with all outputs 0. Words still in flight are dropped because valid is ignored in IDLE, and the partially written line stays tag-invalid.

## Structure
- Shared package cache_pkg holds:
  - the state encoding (IDLE, FILL);
  - BLOCK_OFFSET_BITS = 4;
  - WORDS_PER_BLOCK;
  - the grant encoding (GRANT_I, GRANT_D).
- One sub-module, miss_arbiter: a two-requester round-robin arbiter with the last_grant flop, loaded on the IDLE→FILL transition.
- The counters and the FSM stay in cache_fill_controller.

## Test plan
- Single I miss, I_miss_addr = 16'h1236, memory latency 4 → grant_I high in cycles 1–12; memory_address steps 16'h1230, 16'h1232 … 16'h123E in cycles 1–8; fill_word 0..7 in cycles 5–12; write_tag_array high only in cycle 12; fsm_busy low in cycle 13.
- I_miss and D_miss rise together right after reset → D fill first. When I_miss is still high in IDLE, the I fill follows. A third simultaneous tie goes to D again.
- D fill in progress and I_miss rises in cycle 3 → no change to grant_D or memory_address; the I fill starts one cycle after the D tag write.
- memory_data_valid with random gaps (8 valids over 20 cycles) → exactly 8 write_data_array pulses with fill_word 0..7 in order, and exactly one write_tag_array on the 8th.
- rst pulsed in cycle 6 of a fill, with valids continuing in cycles 7–9 → every output is 0 from cycle 7 on, and no write_data_array pulse occurs.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and constants for the cache refill path.
package cache_pkg;

  localparam int BLOCK_OFFSET_BITS = 4;
  localparam int WORDS_PER_BLOCK   = 8;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

endpackage

// File: rtl/miss_arbiter.sv
// Two-requester round-robin arbiter; last_grant only advances when a fill is launched.
module miss_arbiter
  import cache_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   req_i,
  input  logic   req_d,
  input  logic   load,
  output grant_e grant
);

  grant_e last_grant;

  // A lone request always wins; a tie goes to whoever did not win last time.
  always_comb begin
    grant = GRANT_I;
    if (req_i && req_d)
      grant = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
    else if (req_d)
      grant = GRANT_D;
  end

  always_ff @(posedge clk) begin
    if (rst)
      last_grant <= GRANT_I;
    else if (load)
      last_grant <= grant;
  end

endmodule

// File: rtl/cache_fill_controller.sv
// Refills one cache block from main memory: arbitrates I/D misses, issues the word
// reads, and steers returning words (and finally the tag) into the granted cache.
module cache_fill_controller #(
  parameter int WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK,
  parameter int ADDR_W          = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               I_miss,
  input  logic [ADDR_W-1:0]                  I_miss_addr,
  input  logic                               D_miss,
  input  logic [ADDR_W-1:0]                  D_miss_addr,
  input  logic                               memory_data_valid,
  output logic                               fsm_busy,
  output logic                               grant_I,
  output logic                               grant_D,
  output logic                               mem_en,
  output logic [ADDR_W-1:0]                  memory_address,
  output logic                               write_data_array,
  output logic                               write_tag_array,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word
);
  import cache_pkg::*;

  localparam int CNT_W = $clog2(WORDS_PER_BLOCK);
  // 16-bit words: block offset = word index bits plus the byte bit.
  localparam int OFF_W = CNT_W + 1;
  localparam logic [CNT_W:0]   ISSUE_MAX = WORDS_PER_BLOCK[CNT_W:0];
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_BLOCK - 1);

  fill_state_e              state_q, state_d;
  grant_e                   arb_grant;
  logic [ADDR_W-1:OFF_W]    base_q;
  logic [CNT_W:0]           issue_cnt;
  logic [CNT_W-1:0]         recv_cnt;
  logic                     grant_i_q, grant_d_q;
  logic                     start, done;
  logic [ADDR_W-1:0]        miss_addr;

  assign start     = (state_q == IDLE) && (I_miss || D_miss);
  assign done      = (state_q == FILL) && memory_data_valid && (recv_cnt == LAST_WORD);
  assign miss_addr = (arb_grant == GRANT_D) ? D_miss_addr : I_miss_addr;

  miss_arbiter u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (I_miss),
    .req_d (D_miss),
    .load  (start),
    .grant (arb_grant)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FILL;
      FILL:    if (done)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Requests outside the current block are held off until the fill returns to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q    <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      grant_i_q <= 1'b0;
      grant_d_q <= 1'b0;
    end else if (start) begin
      base_q    <= miss_addr[ADDR_W-1:OFF_W];
      issue_cnt <= '0;
      recv_cnt  <= '0;
      grant_i_q <= (arb_grant == GRANT_I);
      grant_d_q <= (arb_grant == GRANT_D);
    end else if (state_q == FILL) begin
      if (issue_cnt < ISSUE_MAX) issue_cnt <= issue_cnt + 1'b1;
      if (memory_data_valid)     recv_cnt  <= recv_cnt + 1'b1;
      if (done) begin
        grant_i_q <= 1'b0;
        grant_d_q <= 1'b0;
      end
    end
  end

  // Only the array-write strobes and fill_word see memory_data_valid directly.
  always_comb begin
    fsm_busy         = (state_q == FILL);
    grant_I          = grant_i_q;
    grant_D          = grant_d_q;
    mem_en           = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    fill_word        = '0;
    if (state_q == FILL) begin
      mem_en           = (issue_cnt < ISSUE_MAX);
      memory_address   = {base_q, issue_cnt[CNT_W-1:0], 1'b0};
      write_data_array = memory_data_valid;
      write_tag_array  = done;
      if (memory_data_valid) fill_word = recv_cnt;
    end
  end

endmodule
